carry_pipe: RTL

CARRY_PIPE -- requirements
Module: carry_pipe

---
 rtl/carry_pipe_pkg.sv | 31 +++
 rtl/carry_seg.sv | 41 ++++
 rtl/carry_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/carry_pipe_pkg.sv
// -----------------------------------------------------------------------------
// carry_pipe_pkg
// Shared constants and elaboration-time helpers for the carry_pipe block.
// The pipeline keeps its per-stage state in flat packed vectors whose slice
// widths shrink (forwarded operands) or grow (accumulated results) from stage
// to stage. The offset helpers below locate each stage's slice in those vectors.
// No ports (package).
// -----------------------------------------------------------------------------
package carry_pipe_pkg;

  // Largest chain length the block is intended to be built with.
  localparam int MAX_WIDTH = 64;

  // Number of pipeline stages for a given chain length and segment size.
  function automatic int stage_count(input int width, input int seg);
    return width / seg;
  endfunction

  // Bit offset of stage k's result slice. Stage k holds (k+1)*seg result bits,
  // so the offset is seg * (1 + 2 + ... + k).
  function automatic int res_off(input int k, input int seg);
    return seg * k * (k + 1) / 2;
  endfunction

  // Bit offset of stage k's forwarded (not yet evaluated) operand slice.
  // Stage j forwards width - (j+1)*seg bits; this sums that over j < k.
  function automatic int fwd_off(input int k, input int width, input int seg);
    return k * width - seg * k * (k + 1) / 2;
  endfunction

endpackage

// File: rtl/carry_seg.sv
// -----------------------------------------------------------------------------
// carry_seg
// Purely combinational SEG-bit slice of the carry chain. Per bit i:
//   o[i]  = s[i] ^ c(i-1)
//   co[i] = s[i] ? c(i-1) : di[i]
//   c(i)  = co[i]
// Ports:
//   ci_i   : carry into the lowest bit of the slice
//   di_i   : per-bit generate/data input
//   s_i    : per-bit propagate select
//   o_o    : sum bits
//   co_o   : per-bit carry out
//   cout_o : carry out of the top bit (feeds the next slice)
// -----------------------------------------------------------------------------
module carry_seg
  import carry_pipe_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic           ci_i,
  input  logic [SEG-1:0] di_i,
  input  logic [SEG-1:0] s_i,
  output logic [SEG-1:0] o_o,
  output logic [SEG-1:0] co_o,
  output logic           cout_o
);

  always_comb begin
    logic c;
    c    = ci_i;
    o_o  = '0;
    co_o = '0;
    for (int i = 0; i < SEG; i++) begin
      o_o[i]  = s_i[i] ^ c;
      c       = s_i[i] ? c : di_i[i];
      co_o[i] = c;
    end
    cout_o = c;
  end

endmodule

// File: rtl/carry_pipe.sv
// -----------------------------------------------------------------------------
// carry_pipe
// Pipelined carry chain: each stage evaluates SEG bits. Operand bits above the
// current stage travel forward unevaluated (skew), and finished result slices
// ride along until the last stage presents the whole word (deskew).
// A single global advance signal moves every stage at once, so a stalled
// output freezes the whole pipe.
// Optional feature: define CARRY_PIPE_OUTREG_EN to add one output register
// after the last stage (latency STAGES+1 instead of STAGES).
// Ports:
//   CLK       : clock, rising edge
//   RSTN      : asynchronous active-low reset
//   IN_VALID  : operand beat present
//   IN_READY  : beat accepted this cycle
//   CI        : carry in
//   CYINIT    : carry init, ORed with CI
//   DI        : per-bit generate/data input
//   S         : per-bit propagate select
//   OUT_VALID : result beat present
//   OUT_READY : consumer accepts the result
//   O         : sum bits
//   CO        : per-bit carry out
// -----------------------------------------------------------------------------
module carry_pipe
  import carry_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             CI,
  input  logic             CYINIT,
  input  logic [WIDTH-1:0] DI,
  input  logic [WIDTH-1:0] S,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] CO
);

  localparam int STAGES     = stage_count(WIDTH, SEG);
  localparam int RES_BITS   = res_off(STAGES, SEG);
  localparam int FWD_RAW    = fwd_off(STAGES - 1, WIDTH, SEG);
  // A single-stage pipe forwards nothing; the vectors are kept at least one
  // bit wide so the declarations stay legal.
  localparam int FWD_BITS   = (FWD_RAW > 0) ? FWD_RAW : 1;
  localparam int CARRY_BITS = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST_OFF   = res_off(STAGES - 1, SEG);

  logic                  advance;

  logic [STAGES-1:0]     valid_q;
  wire  [STAGES-1:0]     valid_d;
  logic [RES_BITS-1:0]   o_q;
  wire  [RES_BITS-1:0]   o_d;
  logic [RES_BITS-1:0]   co_q;
  wire  [RES_BITS-1:0]   co_d;
  logic [FWD_BITS-1:0]   di_q;
  wire  [FWD_BITS-1:0]   di_d;
  logic [FWD_BITS-1:0]   s_q;
  wire  [FWD_BITS-1:0]   s_d;
  logic [CARRY_BITS-1:0] carry_q;
  wire  [CARRY_BITS-1:0] carry_d;

  if (STAGES == 1) begin : g_no_fwd
    assign di_d    = '0;
    assign s_d     = '0;
    assign carry_d = '0;
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int ROFF = res_off(gi, SEG);

    logic           seg_ci;
    logic [SEG-1:0] seg_di;
    logic [SEG-1:0] seg_s;
    logic [SEG-1:0] seg_o;
    logic [SEG-1:0] seg_co;
    logic           seg_cout;

    carry_seg #(
      .SEG (SEG)
    ) u_seg (
      .ci_i   (seg_ci),
      .di_i   (seg_di),
      .s_i    (seg_s),
      .o_o    (seg_o),
      .co_o   (seg_co),
      .cout_o (seg_cout)
    );

    if (gi == 0) begin : g_head
      assign seg_ci            = CI | CYINIT;
      assign seg_di            = DI[SEG-1:0];
      assign seg_s             = S[SEG-1:0];
      assign valid_d[0]        = IN_VALID;
      assign o_d[ROFF +: SEG]  = seg_o;
      assign co_d[ROFF +: SEG] = seg_co;
    end else begin : g_body
      localparam int PFOFF = fwd_off(gi - 1, WIDTH, SEG);
      localparam int PROFF = res_off(gi - 1, SEG);
      // The lowest SEG bits of the previous stage's forwarded operands are
      // exactly this stage's slice.
      assign seg_ci      = carry_q[gi-1];
      assign seg_di      = di_q[PFOFF +: SEG];
      assign seg_s       = s_q[PFOFF +: SEG];
      assign valid_d[gi] = valid_q[gi-1];
      // New slice goes on top of the finished lower bits.
      assign o_d[ROFF +: (gi+1)*SEG]  = {seg_o,  o_q[PROFF +: gi*SEG]};
      assign co_d[ROFF +: (gi+1)*SEG] = {seg_co, co_q[PROFF +: gi*SEG]};
    end

    if (gi < STAGES - 1) begin : g_fwd
      localparam int FOFF = fwd_off(gi, WIDTH, SEG);
      localparam int RW   = WIDTH - (gi + 1) * SEG;
      assign carry_d[gi] = seg_cout;
      if (gi == 0) begin : g_src_in
        assign di_d[FOFF +: RW] = DI[WIDTH-1:SEG];
        assign s_d[FOFF +: RW]  = S[WIDTH-1:SEG];
      end else begin : g_src_fwd
        localparam int PFOFF2 = fwd_off(gi - 1, WIDTH, SEG);
        assign di_d[FOFF +: RW] = di_q[PFOFF2 + SEG +: RW];
        assign s_d[FOFF +: RW]  = s_q[PFOFF2 + SEG +: RW];
      end
    end else begin : g_tail
      // The final carry is already visible as the top CO bit.
      wire cout_unused = seg_cout;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= '0;
      o_q     <= '0;
      co_q    <= '0;
      di_q    <= '0;
      s_q     <= '0;
      carry_q <= '0;
    end else if (advance) begin
      valid_q <= valid_d;
      o_q     <= o_d;
      co_q    <= co_d;
      di_q    <= di_d;
      s_q     <= s_d;
      carry_q <= carry_d;
    end
  end

`ifdef CARRY_PIPE_OUTREG_EN
  logic             out_valid_q;
  logic [WIDTH-1:0] out_o_q;
  logic [WIDTH-1:0] out_co_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_valid_q <= 1'b0;
      out_o_q     <= '0;
      out_co_q    <= '0;
    end else if (advance) begin
      out_valid_q <= valid_q[STAGES-1];
      out_o_q     <= o_q[LAST_OFF +: WIDTH];
      out_co_q    <= co_q[LAST_OFF +: WIDTH];
    end
  end

  assign OUT_VALID = out_valid_q;
  assign O         = out_o_q;
  assign CO        = out_co_q;
`else
  assign OUT_VALID = valid_q[STAGES-1];
  assign O         = o_q[LAST_OFF +: WIDTH];
  assign CO        = co_q[LAST_OFF +: WIDTH];
`endif

  // Global stall: everything moves only when the output slot is free or taken.
  assign advance  = !OUT_VALID || OUT_READY;
  assign IN_READY = advance;

endmodule
